// File: rtl/uw_interleave.sv
// Unique-word inserter: frames a serial payload into fixed-length frames,
// each opened by the rotation-selected sync byte, MSB first.
module uw_interleave #(
    parameter int BITS_PER_FRAME = 80,
    parameter int NUM_FRAMES     = 32
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic [1:0]                        rotation_in,
    input  logic [$clog2(BITS_PER_FRAME)-1:0] offset_in,
    input  logic                              hard_inp,
    input  logic                              valid_in,
    output logic                              ready_out,
    output logic                              bit_out,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int TOTAL = NUM_FRAMES * BITS_PER_FRAME;
    localparam int PW    = $clog2(BITS_PER_FRAME);
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [PW-1:0] POS_LAST = PW'(BITS_PER_FRAME - 1);
    localparam logic [PW-1:0] SYNC_LEN = PW'(8);
    localparam logic [PW-1:0] BPF_W    = PW'(BITS_PER_FRAME);
    localparam logic [PW:0]   BPF_X    = (PW+1)'(BITS_PER_FRAME);
    localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN
    } state_t;

    state_t        state;
    logic [1:0]    rot;
    logic [PW-1:0] pos;
    logic [CW-1:0] cnt;

    logic [7:0]    sync_byte;
    logic          in_sync;
    logic          adv;
    logic          load;
    logic          sync_bit;
    logic [PW-1:0] start_pos;

    always_comb begin
        case (rot)
            2'd0:    sync_byte = 8'h27;
            2'd1:    sync_byte = 8'h4E;
            2'd2:    sync_byte = 8'hD8;
            default: sync_byte = 8'hB1;
        endcase
    end

    // Offsets outside the frame collapse to zero; otherwise start that
    // many payload bits before the next frame boundary.
    always_comb begin
        if (offset_in == '0 || {1'b0, offset_in} >= BPF_X)
            start_pos = '0;
        else
            start_pos = BPF_W - offset_in;
    end

    assign in_sync   = (pos < SYNC_LEN);
    assign sync_bit  = sync_byte[3'd7 - pos[2:0]];
    assign adv       = !valid_out || ready_in;
    assign load      = (state == SEND) && adv && (in_sync || valid_in);
    assign ready_out = (state == SEND) && !in_sync && adv;
    assign busy_out  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            rot       <= '0;
            pos       <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            valid_out <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        rot   <= rotation_in;
                        pos   <= start_pos;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (load) begin
                        bit_out   <= in_sync ? sync_bit : hard_inp;
                        valid_out <= 1'b1;
                        pos       <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                        cnt       <= cnt + 1'b1;
                        if (cnt == CNT_LAST)
                            state <= DRAIN;
                    end else if (valid_out && ready_in) begin
                        valid_out <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (valid_out && ready_in) begin
                        valid_out <= 1'b0;
                        bit_out   <= 1'b0;
                        done_out  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
